eq_frame_sequencer: RTL and testbench

EQ_FRAME_SEQUENCER -- requirements
Module: eq_frame_sequencer

---
 rtl/eq_pkg.sv | 16 +
 rtl/eq_out_stage.sv | 43 ++++
 rtl/eq_frame_sequencer.sv | 126 ++++++++++++
 tb/tb_eq_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer frame sequencer.
//   state_e          : sequencer FSM states (IDLE / RUN / DRAIN)
//   *_DEF localparams: default geometry used by the sequencer parameters
package eq_pkg;

  localparam int unsigned SAMPLES_DEF    = 2048;  // bins per frame (power of two, >= 2)
  localparam int unsigned SIZE_DEF       = 32;    // bin width: {real, imag}
  localparam int unsigned COEFF_BITS_DEF = 8;     // unsigned gain coefficient width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/eq_out_stage.sv
// One-entry valid/ready output register for the equalized bin stream.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   load_i          : capture load_data_i this cycle (input handshake)
//   load_data_i     : equalizer result to capture
//   out_ready_i     : downstream ready
//   out_valid_o     : register holds a bin
//   out_data_o      : held bin, stable while out_valid_o && !out_ready_i
module eq_out_stage #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] load_data_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [SIZE-1:0] out_data_o
);

  logic            valid_q;
  logic [SIZE-1:0] data_q;

  // A new bin always wins over a drain: the upstream only offers one when the
  // register is empty or being emptied in the same cycle, so nothing is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      // NOTE: non-blocking assignments on every register so all state
      // updates see the pre-edge values, independent of block ordering.
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/eq_frame_sequencer.sv
// Frame sequencer for a combinational bin equalizer.
// In IDLE it forwards coefficient writes to the equalizer; on start it streams
// SAMPLES bins through the equalizer into a one-entry output register, then
// drains that register and pulses done.
// Ports:
//   clk, rst                                : clock, asynchronous active-high reset
//   start, busy, done                       : frame control / status
//   cfg_valid/ready/index/coeff             : coefficient write channel (IDLE only)
//   in_valid/ready/data                     : bin input stream (RUN only)
//   out_valid/ready/data                    : equalized bin output stream
//   eq_index, eq_coeff_wr_en, eq_coeff_in,
//   eq_data_in, eq_data_out                 : equalizer datapath connection;
//                                             eq_index feeds both its input
//                                             and coefficient index ports
module eq_frame_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned SAMPLES    = SAMPLES_DEF,
  parameter int unsigned SIZE       = SIZE_DEF,
  parameter int unsigned COEFF_BITS = COEFF_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(SAMPLES)-1:0] cfg_index,
  input  logic [COEFF_BITS-1:0]      cfg_coeff,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIZE-1:0]            in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE-1:0]            out_data,
  output logic [$clog2(SAMPLES)-1:0] eq_index,
  output logic                       eq_coeff_wr_en,
  output logic [COEFF_BITS-1:0]      eq_coeff_in,
  output logic [SIZE-1:0]            eq_data_in,
  input  logic [SIZE-1:0]            eq_data_out
);

  localparam int unsigned          IDX_W    = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0]     LAST_BIN = IDX_W'(SAMPLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             in_hs;

  // Single-register backpressure: accept a bin whenever the output register
  // is empty or is being emptied this cycle, so full throughput has no bubble.
  assign in_ready = (state_q == RUN) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    cnt_d          = cnt_q;
    cfg_ready      = 1'b0;
    eq_index       = '0;
    eq_coeff_wr_en = 1'b0;
    eq_coeff_in    = '0;
    eq_data_in     = '0;
    done           = 1'b0;

    // The IDLE config path is purely combinational from the inputs, so it is
    // gated explicitly to keep the equalizer quiet while reset is held.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          cfg_ready      = 1'b1;
          eq_index       = cfg_index;
          eq_coeff_wr_en = cfg_valid;
          eq_coeff_in    = cfg_coeff;
          // A coefficient write in the same cycle as start still completes.
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          eq_index   = cnt_q;
          eq_data_in = in_data;
          if (in_hs) begin
            // SAMPLES is a power of two, so the last bin wraps cnt to 0.
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_BIN) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  eq_out_stage #(
    .SIZE (SIZE)
  ) u_out_stage (
    .clk         (clk),
    .rst         (rst),
    .load_i      (in_hs),
    .load_data_i (eq_data_out),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data)
  );

endmodule

// File: tb/tb_eq_frame_sequencer.sv
// Self-checking bench for eq_frame_sequencer (SAMPLES=8). The equalizer is a
// behavioural model: per-bin coefficient store (unity = 32) scaling the signed
// real and imaginary halves, with coefficients held across sequencer resets.
module tb_eq_frame_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, busy, done;
  logic          cfg_valid, cfg_ready;
  logic [IW-1:0] cfg_index;
  logic [7:0]    cfg_coeff;
  logic          in_valid, in_ready;
  logic [31:0]   in_data;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic [IW-1:0] eq_index;
  logic          eq_coeff_wr_en;
  logic [7:0]    eq_coeff_in;
  logic [31:0]   eq_data_in, eq_data_out;

  always #5 clk = ~clk;

  eq_frame_sequencer #(
    .SAMPLES    (N),
    .SIZE       (32),
    .COEFF_BITS (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_index      (cfg_index),
    .cfg_coeff      (cfg_coeff),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .eq_index       (eq_index),
    .eq_coeff_wr_en (eq_coeff_wr_en),
    .eq_coeff_in    (eq_coeff_in),
    .eq_data_in     (eq_data_in),
    .eq_data_out    (eq_data_out)
  );

  // ---------------- equalizer model ----------------
  logic [7:0] coeff_mem [N];

  function automatic logic [31:0] eq_apply(input logic [31:0] d, input logic [7:0] c);
    int re, im, pr, pi;
    re = int'($signed(d[31:16]));
    im = int'($signed(d[15:0]));
    pr = (re * int'(c)) >>> 5;
    pi = (im * int'(c)) >>> 5;
    return {pr[15:0], pi[15:0]};
  endfunction

  initial for (int k = 0; k < N; k++) coeff_mem[k] = 8'd32;

  always @(posedge clk) if (eq_coeff_wr_en) coeff_mem[eq_index] <= eq_coeff_in;

  always_comb eq_data_out = eq_apply(eq_data_in, coeff_mem[eq_index]);

  // ---------------- monitors ----------------
  logic [31:0] out_q [$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) out_q.push_back(out_data);
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Vector table: bin input, expected output with bin-5 coefficient at unity
  // (exp1) and after bin 5 is set to 16 = half gain (exp2). Bin 3 gets 64.
  typedef struct {
    logic [31:0] din;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t tbl [N];

  function automatic logic [31:0] exp_of(input int i, input bit use2);
    return use2 ? tbl[i].exp2 : tbl[i].exp1;
  endfunction

  // Present bin i for one cycle with downstream ready; check the RUN-side
  // combinational outputs before the edge and the registered result after.
  task automatic send_bin(input int i, input bit use2);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = tbl[i].din;
    #1;
    check($sformatf("run_in_ready[%0d]", i), 32'(in_ready), 32'd1);
    check($sformatf("run_eq_index[%0d]", i), 32'(eq_index), 32'(i));
    check($sformatf("run_eq_data_in[%0d]", i), eq_data_in, tbl[i].din);
    check($sformatf("run_cfg_ready[%0d]", i), 32'(cfg_ready), 32'd0);
    check($sformatf("run_wr_en[%0d]", i), 32'(eq_coeff_wr_en), 32'd0);
    @(posedge clk); #1;
    check($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'd1);
    check($sformatf("out_data[%0d]", i), out_data, exp_of(i, use2));
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("idle_data_not_taken", 32'(out_valid), 32'd0);
  endtask

  // Final DRAIN cycle with ready high: done pulses once and the FSM idles.
  task automatic finish_frame();
    int d0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5555_5555;
    #1;
    d0 = done_cnt;
    check("drain_in_ready", 32'(in_ready), 32'd0);
    check("drain_done", 32'(done), 32'd1);
    check("drain_cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check("end_busy", 32'(busy), 32'd0);
    check("end_out_valid", 32'(out_valid), 32'd0);
    check("end_done_low", 32'(done), 32'd0);
    check("done_pulse_count", 32'(done_cnt), 32'(d0 + 1));
    check("end_cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  task automatic check_queue(input bit use2);
    check("out_count", 32'(out_q.size()), 32'(N));
    for (int i = 0; i < N && i < out_q.size(); i++)
      check($sformatf("out_order[%0d]", i), out_q[i], exp_of(i, use2));
    out_q.delete();
  endtask

  task automatic run_table_frame(input bit use2);
    start_pulse();
    for (int i = 0; i < N; i++) send_bin(i, use2);
    finish_frame();
    check_queue(use2);
  endtask

  initial begin
    int d_before;

    tbl[0] = '{32'h0011_0022, 32'h0011_0022, 32'h0011_0022};
    tbl[1] = '{32'h1234_0567, 32'h1234_0567, 32'h1234_0567};
    tbl[2] = '{32'h0F00_00F0, 32'h0F00_00F0, 32'h0F00_00F0};
    tbl[3] = '{32'h0100_0200, 32'h0200_0400, 32'h0200_0400};
    tbl[4] = '{32'h0040_FFC0, 32'h0040_FFC0, 32'h0040_FFC0};
    tbl[5] = '{32'h7FFF_8000, 32'h7FFF_8000, 32'h3FFF_C000};
    tbl[6] = '{32'h0001_0002, 32'h0001_0002, 32'h0001_0002};
    tbl[7] = '{32'hABCD_1357, 32'hABCD_1357, 32'hABCD_1357};

    // ---- reset: busy IDLE-side inputs must not leak through ----
    rst = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_index = 3'd6; cfg_coeff = 8'd9;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(eq_coeff_wr_en), 32'd0);
    check("rst_eq_index", 32'(eq_index), 32'd0);
    check("rst_coeff_in", 32'(eq_coeff_in), 32'd0);
    start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    // ---- coefficient write: bin 3 gain x2 ----
    @(negedge clk);
    cfg_valid = 1'b1; cfg_index = 3'd3; cfg_coeff = 8'd64;
    #1;
    check("cfg_wr_en", 32'(eq_coeff_wr_en), 32'd1);
    check("cfg_eq_index", 32'(eq_index), 32'd3);
    check("cfg_coeff_in", 32'(eq_coeff_in), 32'd64);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("cfg_idle_busy", 32'(busy), 32'd0);

    // ---- frame 1: full throughput ----
    run_table_frame(1'b0);

    // ---- frame 2: 3-cycle backpressure at bin 2 ----
    start_pulse();
    for (int i = 0; i < 3; i++) send_bin(i, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = tbl[3].din;
      #1;
      check($sformatf("stall_in_ready[%0d]", k), 32'(in_ready), 32'd0);
      check($sformatf("stall_out_valid[%0d]", k), 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      check($sformatf("stall_out_data[%0d]", k), out_data, tbl[2].exp1);
    end
    for (int i = 3; i < N; i++) send_bin(i, 1'b0);
    finish_frame();
    check_queue(1'b0);

    // ---- frame 3: start + cfg write collide, start/cfg held through frame ----
    @(negedge clk);
    start = 1'b1; cfg_valid = 1'b1; cfg_index = 3'd5; cfg_coeff = 8'd16;
    #1;
    check("coll_wr_en", 32'(eq_coeff_wr_en), 32'd1);
    check("coll_eq_index", 32'(eq_index), 32'd5);
    check("coll_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    check("coll_busy", 32'(busy), 32'd1);
    check("coll_run_cfg_ready", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < N; i++) send_bin(i, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check($sformatf("drain_hold_done[%0d]", k), 32'(done), 32'd0);
      check($sformatf("drain_hold_in_ready[%0d]", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("drain_hold_busy[%0d]", k), 32'(busy), 32'd1);
      check($sformatf("drain_hold_data[%0d]", k), out_data, tbl[7].exp2);
    end
    finish_frame();
    check_queue(1'b1);

    // ---- frame 4: reset after bin 4 accepted ----
    start_pulse();
    for (int i = 0; i < 5; i++) send_bin(i, 1'b1);
    d_before = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'(d_before));
    out_q.delete();

    // ---- frame 5: clean frame from index 0, coefficients retained ----
    run_table_frame(1'b1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
